// File: rtl/axi_mem_slave.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) burst engines over a word array.
// Optional build macro AXI_MEM_OOR_SLVERR_EN rejects bursts that leave the mapped window.
module axi_mem_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 4,
  parameter int MEM_WORDS = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] MEM_BASE = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                        S_AXI_AWVALID,
  output logic                        S_AXI_AWREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [1:0]                  S_AXI_AWBURST,
  input  logic [2:0]                  S_AXI_AWSIZE,
  input  logic [7:0]                  S_AXI_AWLEN,
  input  logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  input  logic                        S_AXI_WLAST,
  output logic [1:0]                  S_AXI_BRESP,
  output logic                        S_AXI_BVALID,
  input  logic                        S_AXI_BREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_BID,
  input  logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                        S_AXI_ARVALID,
  output logic                        S_AXI_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [1:0]                  S_AXI_ARBURST,
  input  logic [2:0]                  S_AXI_ARSIZE,
  input  logic [7:0]                  S_AXI_ARLEN,
  output logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                  S_AXI_RRESP,
  output logic                        S_AXI_RVALID,
  input  logic                        S_AXI_RREADY,
  output logic [AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic                        S_AXI_RLAST
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - MEM_BASE;
    return IDX_W'(off >> 3);
  endfunction

  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                          input logic [1:0] burst);
    return (burst == BURST_INCR) ? a + AXI_ADDR_WIDTH'(8) : a;
  endfunction

  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return ((burst == BURST_FIXED) || (burst == BURST_INCR)) && (size == 3'd3);
  endfunction

  logic aw_legal;
  logic ar_legal;

`ifdef AXI_MEM_OOR_SLVERR_EN
  localparam int EW = AXI_ADDR_WIDTH + 12;

  // Compared in a wider width so the window end and the last beat cannot overflow.
  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a, input logic [7:0] len,
                                    input logic [1:0] burst);
    logic [EW-1:0] first;
    logic [EW-1:0] last;
    logic [EW-1:0] lim;
    first = EW'(a);
    last = first + ((burst == BURST_INCR) ? (EW'(len) << 3) : EW'(0));
    lim = EW'(MEM_BASE) + (EW'(MEM_WORDS) << 3);
    return (first >= EW'(MEM_BASE)) && (last < lim);
  endfunction

  assign aw_legal = burst_ok(S_AXI_AWBURST, S_AXI_AWSIZE) &&
                    in_range(S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST);
  assign ar_legal = burst_ok(S_AXI_ARBURST, S_AXI_ARSIZE) &&
                    in_range(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST);
`else
  assign aw_legal = burst_ok(S_AXI_AWBURST, S_AXI_AWSIZE);
  assign ar_legal = burst_ok(S_AXI_ARBURST, S_AXI_ARSIZE);
`endif

  w_state_t                  w_state;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [7:0]                w_len;
  logic [7:0]                w_beat;
  logic [1:0]                w_burst;
  logic                      w_legal;
  logic                      w_over;
  logic                      mem_we;
  logic [IDX_W-1:0]          w_idx;

  // w_over marks beats beyond AWLEN: they are still accepted but never stored.
  assign w_idx = word_idx(w_addr);
  assign mem_we = rst_n && (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY &&
                  w_legal && !w_over;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      S_AXI_BID     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (S_AXI_AWVALID) begin
            w_addr        <= S_AXI_AWADDR;
            w_len         <= S_AXI_AWLEN;
            w_burst       <= S_AXI_AWBURST;
            w_legal       <= aw_legal;
            w_beat        <= '0;
            w_over        <= 1'b0;
            S_AXI_BID     <= S_AXI_AWID;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_addr <= next_addr(w_addr, w_burst);
            if (S_AXI_WLAST) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= (!w_legal || w_over || (w_beat != w_len)) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else if (w_beat == w_len) begin
              w_over <= 1'b1;
            end else begin
              w_beat <= w_beat + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (S_AXI_WSTRB[i]) mem[w_idx][8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
      end
    end
  end

  r_state_t                  r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                r_len;
  logic [7:0]                r_beat;
  logic [1:0]                r_burst;
  logic                      r_legal;
  logic [IDX_W-1:0]          r_idx;

  // r_addr always holds the address of the next beat to be loaded into RDATA.
  assign r_idx = (r_state == R_IDLE) ? word_idx(S_AXI_ARADDR) : word_idx(r_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RLAST   <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RID     <= '0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            r_addr        <= next_addr(S_AXI_ARADDR, S_AXI_ARBURST);
            r_len         <= S_AXI_ARLEN;
            r_burst       <= S_AXI_ARBURST;
            r_legal       <= ar_legal;
            r_beat        <= '0;
            S_AXI_RID     <= S_AXI_ARID;
            S_AXI_RRESP   <= ar_legal ? RESP_OKAY : RESP_SLVERR;
            S_AXI_RDATA   <= ar_legal ? mem[r_idx] : '0;
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              S_AXI_RDATA <= r_legal ? mem[r_idx] : '0;
              S_AXI_RLAST <= ((r_beat + 8'd1) == r_len);
              r_addr      <= next_addr(r_addr, r_burst);
              r_beat      <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Randomized bench for axi_mem_slave against an array-based memory model with AXI legality rules.
module tb_axi_mem_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS = 1024;
`ifdef AXI_MEM_OOR_SLVERR_EN
  localparam bit OOR_EN = 1'b1;
`else
  localparam bit OOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [3:0]  S_AXI_AWID = '0;
  logic [1:0]  S_AXI_AWBURST = '0;
  logic [2:0]  S_AXI_AWSIZE = '0;
  logic [7:0]  S_AXI_AWLEN = '0;
  logic [63:0] S_AXI_WDATA = '0;
  logic [7:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic        S_AXI_WLAST = 1'b0;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [3:0]  S_AXI_BID;
  logic [31:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [3:0]  S_AXI_ARID = '0;
  logic [1:0]  S_AXI_ARBURST = '0;
  logic [2:0]  S_AXI_ARSIZE = '0;
  logic [7:0]  S_AXI_ARLEN = '0;
  logic [63:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [3:0]  S_AXI_RID;
  logic        S_AXI_RLAST;

  axi_mem_slave dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_BID(S_AXI_BID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARBURST(S_AXI_ARBURST),
    .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_RDATA(S_AXI_RDATA),
    .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .S_AXI_RID(S_AXI_RID), .S_AXI_RLAST(S_AXI_RLAST)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] model [WORDS];
  logic [63:0] wd [300];
  logic [7:0]  ws [300];
  int rr_pat[$];
  logic [63:0] last_rdata;
  logic [1:0]  last_rresp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off / 8) % WORDS;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] burst, input int b);
    return (burst == 2'b01) ? a + 32'(8 * b) : a;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [7:0] len,
                               input logic [1:0] burst, input logic [2:0] size);
    longint first;
    longint last;
    bit in_rng;
    first = longint'(a);
    last = first + ((burst == 2'b01) ? 8 * longint'(len) : 0);
    in_rng = (first >= longint'(BASE)) && (last < longint'(BASE) + 8 * WORDS);
    return (burst == 2'b00 || burst == 2'b01) && size == 3'd3 && (!OOR_EN || in_rng);
  endfunction

  task automatic chk_reset_state();
    chk("rst_awready", S_AXI_AWREADY, 1);
    chk("rst_arready", S_AXI_ARREADY, 1);
    chk("rst_wready", S_AXI_WREADY, 0);
    chk("rst_bvalid", S_AXI_BVALID, 0);
    chk("rst_rvalid", S_AXI_RVALID, 0);
    chk("rst_rlast", S_AXI_RLAST, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    chk("rst_ids", {S_AXI_BID, S_AXI_RID}, 0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input int nbeats);
    int n;
    bit hs;
    bit ok;
    logic [1:0] got_resp;
    logic [3:0] got_id;
    logic [63:0] w;
    ok = legal(addr, len, burst, size);
    S_AXI_AWADDR = addr; S_AXI_AWID = id; S_AXI_AWLEN = len;
    S_AXI_AWBURST = burst; S_AXI_AWSIZE = size; S_AXI_AWVALID = 1'b1;
    n = 0;
    do begin hs = S_AXI_AWREADY; tick(); n++; end while (!hs && n < 200);
    S_AXI_AWVALID = 1'b0;
    if (!hs) begin chk("aw_timeout", 0, 1); return; end
    for (int b = 0; b < nbeats; b++) begin
      S_AXI_WVALID = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      S_AXI_WDATA = wd[b]; S_AXI_WSTRB = ws[b];
      S_AXI_WLAST = (b == nbeats - 1); S_AXI_WVALID = 1'b1;
      n = 0;
      do begin hs = S_AXI_WREADY; tick(); n++; end while (!hs && n < 200);
      if (!hs) begin chk("w_timeout", 0, 1); S_AXI_WVALID = 1'b0; return; end
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    chk("b_latency", S_AXI_BVALID, 1);
    repeat ($urandom_range(0, 2)) begin chk("b_hold", S_AXI_BVALID, 1); tick(); end
    S_AXI_BREADY = 1'b1;
    n = 0;
    do begin
      hs = S_AXI_BVALID; got_resp = S_AXI_BRESP; got_id = S_AXI_BID; tick(); n++;
    end while (!hs && n < 200);
    S_AXI_BREADY = 1'b0;
    chk("bresp", got_resp, (ok && nbeats == int'(len) + 1) ? 2'b00 : 2'b10);
    chk("bid", got_id, id);
    chk("awready_after_b", S_AXI_AWREADY, 1);
    if (ok) begin
      for (int b = 0; b < nbeats && b <= int'(len); b++) begin
        w = model[widx(beat_addr(addr, burst, b))];
        for (int k = 0; k < 8; k++) if (ws[b][k]) w[8*k +: 8] = wd[b][8*k +: 8];
        model[widx(beat_addr(addr, burst, b))] = w;
      end
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input int rst_at);
    int n;
    int b;
    bit hs;
    bit ok;
    logic [63:0] exp_d;
    ok = legal(addr, len, burst, size);
    S_AXI_ARADDR = addr; S_AXI_ARID = id; S_AXI_ARLEN = len;
    S_AXI_ARBURST = burst; S_AXI_ARSIZE = size; S_AXI_ARVALID = 1'b1;
    n = 0;
    do begin hs = S_AXI_ARREADY; tick(); n++; end while (!hs && n < 200);
    S_AXI_ARVALID = 1'b0;
    if (!hs) begin chk("ar_timeout", 0, 1); return; end
    chk("rvalid_latency", S_AXI_RVALID, 1);
    b = 0;
    n = 0;
    while (b <= int'(len) && n < 2000) begin
      if (b == rst_at) begin
        S_AXI_RREADY = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset_state();
        return;
      end
      if (rr_pat.size() > 0) S_AXI_RREADY = (rr_pat.pop_front() != 0);
      else S_AXI_RREADY = ($urandom_range(0, 3) != 0);
      exp_d = ok ? model[widx(beat_addr(addr, burst, b))] : 64'd0;
      chk("rvalid", S_AXI_RVALID, 1);
      chk("rdata", S_AXI_RDATA, exp_d);
      chk("rlast", S_AXI_RLAST, b == int'(len));
      chk("rresp", S_AXI_RRESP, ok ? 2'b00 : 2'b10);
      chk("rid", S_AXI_RID, id);
      last_rdata = S_AXI_RDATA;
      last_rresp = S_AXI_RRESP;
      hs = S_AXI_RVALID && S_AXI_RREADY;
      tick();
      n++;
      if (hs) b++;
    end
    S_AXI_RREADY = 1'b0;
    if (n >= 2000) chk("r_timeout", 0, 1);
    chk("rvalid_done", S_AXI_RVALID, 0);
    chk("arready_done", S_AXI_ARREADY, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_reset_state();
    rst_n = 1'b1;
    tick();

    // Fill the whole array so every later read has a known model value.
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
      axi_write(BASE + 32'(k * 2048), 4'(k), 8'd255, 2'b01, 3'd3, 256);
    end

    wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
    axi_write(BASE, 4'd5, 8'd0, 2'b01, 3'd3, 1);
    axi_read(BASE, 4'd6, 8'd0, 2'b01, 3'd3, -1);
    chk("single_rdata", last_rdata, 64'hDEADBEEF_CAFEF00D);

    for (int b = 0; b < 4; b++) begin wd[b] = 64'(b + 1); ws[b] = 8'hFF; end
    axi_write(BASE + 32'h20, 4'd1, 8'd3, 2'b01, 3'd3, 4);
    rr_pat = {1, 0, 1, 1, 0, 1};
    axi_read(BASE + 32'h20, 4'd2, 8'd3, 2'b01, 3'd3, -1);
    chk("incr4_last", last_rdata, 64'd4);

    wd[0] = '1; ws[0] = 8'hFF;
    axi_write(BASE + 32'h100, 4'd3, 8'd0, 2'b01, 3'd3, 1);
    wd[0] = '0; ws[0] = 8'h0F;
    axi_write(BASE + 32'h100, 4'd3, 8'd0, 2'b01, 3'd3, 1);
    axi_read(BASE + 32'h100, 4'd3, 8'd0, 2'b01, 3'd3, -1);
    chk("strb_merge", last_rdata, 64'hFFFFFFFF_00000000);

    for (int b = 0; b < 5; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'hFF; end
    axi_write(BASE + 32'h200, 4'd7, 8'd3, 2'b01, 3'd3, 3);
    axi_write(BASE + 32'h200, 4'd8, 8'd3, 2'b01, 3'd3, 5);
    axi_write(BASE + 32'h200, 4'd9, 8'd3, 2'b01, 3'd3, 4);
    axi_read(BASE + 32'h200, 4'd9, 8'd3, 2'b01, 3'd3, -1);

    axi_write(BASE + 32'h300, 4'd4, 8'd3, 2'b10, 3'd3, 4);
    axi_read(BASE + 32'h300, 4'd4, 8'd3, 2'b01, 3'd3, -1);
    axi_read(BASE + 32'h300, 4'd4, 8'd3, 2'b01, 3'd2, -1);
    chk("size2_rresp", last_rresp, 2'b10);

    axi_read(BASE + 32'h400, 4'd10, 8'd7, 2'b01, 3'd3, 3);
    tick();
    axi_read(BASE + 32'h400, 4'd11, 8'd7, 2'b01, 3'd3, -1);

    axi_read(32'h0000_0000, 4'd12, 8'd0, 2'b01, 3'd3, -1);
    chk("oor_rresp", last_rresp, OOR_EN ? 2'b10 : 2'b00);

    wd[0] = 64'h1111; wd[1] = 64'h2222; ws[0] = 8'hFF; ws[1] = 8'hFF;
    fork
      axi_write(BASE + 32'h500, 4'd13, 8'd1, 2'b01, 3'd3, 2);
      axi_read(BASE + 32'h600, 4'd14, 8'd1, 2'b01, 3'd3, -1);
    join
    axi_read(BASE + 32'h500, 4'd13, 8'd1, 2'b01, 3'd3, -1);

    for (int it = 0; it < 40; it++) begin
      logic [31:0] a;
      logic [7:0] l;
      logic [1:0] bt;
      logic [2:0] sz;
      int nb;
      int r;
      a = BASE + 32'(8 * $urandom_range(0, WORDS - 1));
      if ($urandom_range(0, 7) == 0) a = $urandom & 32'hFFFF_FFF8;
      l = 8'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      bt = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      sz = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
      if ($urandom_range(0, 1) == 0) begin
        nb = int'(l) + 1;
        r = $urandom_range(0, 7);
        if (r == 0 && l != 0) nb = int'(l);
        else if (r == 1) nb = int'(l) + 2;
        for (int b = 0; b < nb; b++) begin wd[b] = {$urandom, $urandom}; ws[b] = 8'($urandom); end
        axi_write(a, 4'($urandom), l, bt, sz, nb);
      end else begin
        axi_read(a, 4'($urandom), l, bt, sz, -1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
